// File: rtl/token_loader.sv
// Token loader: streams one token into the matcher input RAM, appends a 0 terminator,
// pulses cs and holds the buffer until match_done. Optional tok_len output: TOKEN_LOADER_LEN_EN.
//   state | meaning
//   IDLE  | waiting for first beat of a token
//   LOAD  | accepting payload bytes
//   TERM  | writing the 0 terminator
//   START | one-cycle cs pulse to the matcher
//   WAIT  | buffer held until match_done
//   DRAIN | discarding the rest of a failed token
module token_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic [ADDR_WIDTH-1:0] input_start_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  cs,
  input  logic                  match_done,
  output logic                  busy,
  output logic                  err
`ifdef TOKEN_LOADER_LEN_EN
  ,
  output logic [ADDR_WIDTH-1:0] tok_len
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TERM  = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   wptr, wptr_nx;
  logic [ADDR_WIDTH-1:0]   base, base_nx;
  logic                    err_nx;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    ready_st;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  assign ready_st = (state == IDLE) || (state == LOAD) || (state == DRAIN);
  // Held low during reset even though the state register already reads IDLE.
  assign s_ready  = ready_st & rst_n;
  assign accept   = s_valid & s_ready;
  assign busy     = (state != IDLE);
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wptr  <= '0;
      base  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      wptr  <= wptr_nx;
      base  <= base_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wptr_nx  = wptr;
    base_nx  = base;
    err_nx   = err;
    we       = 1'b0;
    waddr    = wptr;
    wdata    = s_data;
    cs       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_data == '0) begin
            err_nx   = 1'b1;
            state_nx = s_last ? IDLE : DRAIN;
          end else begin
            we      = 1'b1;
            waddr   = input_start_addr;
            base_nx = input_start_addr;
            err_nx  = 1'b0;
            // A byte in the top slot leaves no room for the terminator.
            if (input_start_addr == ADDR_MAX) begin
              wptr_nx  = input_start_addr;
              err_nx   = 1'b1;
              state_nx = s_last ? IDLE : DRAIN;
            end else begin
              wptr_nx  = input_start_addr + 1'b1;
              state_nx = s_last ? TERM : LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if ((s_data == '0) || (wptr == ADDR_MAX)) begin
            err_nx   = 1'b1;
            state_nx = s_last ? IDLE : DRAIN;
          end else begin
            we       = 1'b1;
            wptr_nx  = wptr + 1'b1;
            state_nx = s_last ? TERM : LOAD;
          end
        end
      end
      TERM: begin
        we       = 1'b1;
        wdata    = '0;
        state_nx = START;
      end
      START: begin
        cs       = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (match_done) state_nx = IDLE;
      end
      DRAIN: begin
        if (accept && s_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef TOKEN_LOADER_LEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             tok_len <= '0;
    else if (state == TERM) tok_len <= wptr - base;
  end
`endif

endmodule

// File: tb/tb_token_loader.sv
// Randomized bench for token_loader against a per-token reference model of RAM, err, cs and length.
module tb_token_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic [3:0] input_start_addr = 4'h0;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;
  logic       cs;
  logic       match_done = 1'b0;
  logic       busy;
  logic       err;
`ifdef TOKEN_LOADER_LEN_EN
  logic [3:0] tok_len;
`endif

  always #5 clk = ~clk;

  token_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .input_start_addr(input_start_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .cs(cs), .match_done(match_done), .busy(busy), .err(err)
`ifdef TOKEN_LOADER_LEN_EN
    , .tok_len(tok_len)
`endif
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cs_cnt = 0;
  logic [7:0] mmem [16];
  bit         mknown [16];
  int         exp_len = 0;
  logic [7:0] tok [$];
  bit         gaps = 1'b0;

  always @(posedge clk) begin
    #2;
    if (cs === 1'b1) cs_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tok(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    tok.delete();
    for (int i = 0; i < n; i++) tok.push_back(b[i]);
  endtask

  // Address-walk model: the terminator needs a free slot, and nothing may land past 15.
  task automatic model_token(input int start, output bit ok, output int len);
    int a;
    bit e;
    a = start;
    e = 1'b0;
    len = 0;
    for (int i = 0; i < tok.size(); i++) begin
      if (tok[i] == 8'h00) begin e = 1'b1; break; end
      if (i > 0 && a == 15) begin e = 1'b1; break; end
      mmem[a] = tok[i];
      mknown[a] = 1'b1;
      if (a == 15) begin e = 1'b1; break; end
      a++;
    end
    if (!e) begin
      mmem[a] = 8'h00;
      mknown[a] = 1'b1;
      len = a - start;
    end
    ok = !e;
  endtask

  task automatic check_mem();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      if (mknown[a]) check($sformatf("mem[%0d]", a), {24'h0, rd_data}, {24'h0, mmem[a]});
    end
    @(negedge clk);
  endtask

  task automatic run_token(input logic [3:0] start);
    bit ok;
    int len;
    int cs0;
    int guard;
    model_token(int'(start), ok, len);
    cs0 = cs_cnt;
    for (int i = 0; i < tok.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = tok[i];
      s_last  = (i == tok.size() - 1);
      input_start_addr = (i == 0) ? start : 4'($urandom);
      guard = 0;
      while (s_ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        check("ready_timeout", 32'(guard), 32'd0);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (ok) begin
      check("term_cs", cs, 1'b0);
      check("term_busy", busy, 1'b1);
      check("term_ready", s_ready, 1'b0);
      @(negedge clk);
      check("start_cs", cs, 1'b1);
      @(negedge clk);
      check("wait_cs", cs, 1'b0);
      check("wait_busy", busy, 1'b1);
      check("ok_err", err, 1'b0);
      exp_len = len;
`ifdef TOKEN_LOADER_LEN_EN
      check("tok_len", tok_len, 4'(exp_len));
`endif
      repeat ($urandom_range(1, 4)) begin
        s_valid = 1'b1;
        s_data  = 8'h42;
        s_last  = 1'($urandom_range(0, 1));
        check("wait_ready", s_ready, 1'b0);
        @(negedge clk);
        check("wait_hold", busy, 1'b1);
      end
      match_done = 1'b1;
      @(negedge clk);
      match_done = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("done_busy", busy, 1'b0);
      check("done_ready", s_ready, 1'b1);
    end else begin
      check("err_busy", busy, 1'b0);
      check("err_flag", err, 1'b1);
      match_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      match_done = 1'b0;
`ifdef TOKEN_LOADER_LEN_EN
      check("tok_len_hold", tok_len, 4'(exp_len));
`endif
    end
    repeat (2) @(negedge clk);
    check("cs_count", 32'(cs_cnt - cs0), ok ? 32'd1 : 32'd0);
    check_mem();
  endtask

  initial begin
    int n;
    int cs0;
    logic [7:0] b;
    for (int a = 0; a < 16; a++) mknown[a] = 1'b0;
    #1;
    check("rst_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cs", cs, 1'b0);
    check("rst_err", err, 1'b0);
`ifdef TOKEN_LOADER_LEN_EN
    check("rst_tok_len", tok_len, 4'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_tok(3, 8'h63, 8'h61, 8'h74, 8'h00); run_token(4'd2);
    set_tok(4, 8'h01, 8'h02, 8'h03, 8'h04); run_token(4'd12);
    set_tok(4, 8'h41, 8'h00, 8'h42, 8'h43); run_token(4'd0);
    set_tok(1, 8'h41, 8'h00, 8'h00, 8'h00); run_token(4'd7);
    set_tok(1, 8'h42, 8'h00, 8'h00, 8'h00); run_token(4'd9);
    set_tok(1, 8'h5a, 8'h00, 8'h00, 8'h00); run_token(4'd15);

    // Reset after two of five bytes.
    cs0 = cs_cnt;
    s_valid = 1'b1; s_last = 1'b0; input_start_addr = 4'd5; s_data = 8'h11;
    @(negedge clk);
    s_data = 8'h22; input_start_addr = 4'd0;
    @(negedge clk);
    mmem[5] = 8'h11; mknown[5] = 1'b1;
    mmem[6] = 8'h22; mknown[6] = 1'b1;
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_ready", s_ready, 1'b0);
    check("mrst_cs", cs, 1'b0);
    exp_len = 0;
`ifdef TOKEN_LOADER_LEN_EN
    check("mrst_tok_len", tok_len, 4'h0);
`endif
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_cs_count", 32'(cs_cnt - cs0), 32'd0);
    check_mem();

    set_tok(4, 8'h31, 8'h32, 8'h33, 8'h34); run_token(4'd3);
    set_tok(2, 8'h10, 8'h00, 8'h00, 8'h00); run_token(4'd1);

    gaps = 1'b1;
    repeat (60) begin
      n = $urandom_range(1, 6);
      tok.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 11) == 0) b = 8'h00;
        tok.push_back(b);
      end
      run_token(4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
